// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - load/store opcodes (instruction bits [31:26])
//   - FSM state encoding (IDLE / BUSY)
//   - access size enum
//   - decode and alignment helper functions
package mem_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // valid: opcode is one of the supported loads/stores.
  // sign : load result is sign-extended (LB/LH).
  typedef struct packed {
    logic  valid;
    size_e size;
    logic  sign;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [5:0] op);
    op_info_t info;
    info.valid = 1'b1;
    info.size  = SZ_W;
    info.sign  = 1'b0;
    case (op)
      OP_LB:  begin info.size = SZ_B; info.sign = 1'b1; end
      OP_LBU: info.size = SZ_B;
      OP_LH:  begin info.size = SZ_H; info.sign = 1'b1; end
      OP_LHU: info.size = SZ_H;
      OP_LW:  info.size = SZ_W;
      OP_SB:  info.size = SZ_B;
      OP_SH:  info.size = SZ_H;
      OP_SW:  info.size = SZ_W;
      default: info.valid = 1'b0;
    endcase
    return info;
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for a little-endian 32-bit data bus.
// Ports:
//   addr_lo   in  2   byte offset within the word
//   size      in  2   access size (size_e)
//   sign      in  1   sign-extend the loaded byte/half
//   rt        in  32  store data (unshifted)
//   rdata     in  32  bus read data
//   be        out 4   byte enables for the access
//   wdata     out 32  store data replicated onto every lane of its size
//   load_data out 32  selected lane, sign- or zero-extended
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        sign,
  input  logic [31:0] rt,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (addr_lo)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = 8'h00;
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be        = 4'h0;
    wdata     = 32'h0;
    load_data = 32'h0;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{rt[7:0]}};
        load_data = sign ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
      end
      SZ_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{rt[15:0]}};
        load_data = sign ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
      end
      default: begin
        be        = 4'hF;
        wdata     = rt;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage pipeline. Issues loads/stores from EX/MEM onto
// the data-memory bus, stalls the pipeline while the access is outstanding,
// and registers the MEM/WB outputs.
// Ports:
//   clk, rst                         clock, async active-high reset
//   memr_in, memw_in, regw_in,
//   mem2r_in, reg_rd_in, alu_c_in,
//   rt_data_in, instr_in             EX/MEM pipeline register contents
//   dm_req, dm_we, dm_addr, dm_be,
//   dm_wdata                         registered bus request
//   dm_ready, dm_rdata               bus completion and read data
//   mem_stall                        combinational hold of upstream stages
//   misalign, bus_err                one-cycle error pulses
//   wb_regw, wb_mem2r, wb_rd,
//   wb_alu_c, wb_load_data           MEM/WB pipeline register
//
// Bus handshake: dm_req rises on the edge that enters BUSY and, together with
// dm_we/dm_addr/dm_be/dm_wdata, stays constant until the first cycle in which
// dm_ready is sampled high (the transfer completes on that edge) or until the
// timeout abort. dm_ready outside BUSY carries no meaning and is ignored.
// dm_rdata is only consumed in the cycle dm_ready is high.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memr_in,
  input  logic        memw_in,
  input  logic        regw_in,
  input  logic        mem2r_in,
  input  logic [4:0]  reg_rd_in,
  input  logic [31:0] alu_c_in,
  input  logic [31:0] rt_data_in,
  input  logic [31:0] instr_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        wb_regw,
  output logic        wb_mem2r,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_alu_c,
  output logic [31:0] wb_load_data
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  // Decode of the instruction currently in EX/MEM.
  op_info_t dec;
  logic     access;
  logic     mis;

  assign dec    = decode_op(instr_in[31:26]);
  assign access = (memr_in | memw_in) & dec.valid;
  assign mis    = is_misaligned(dec.size, alu_c_in[1:0]);

  // FSM and counter state
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;

  // Attributes of the outstanding access, captured at issue so the load
  // result is formed from the issued request, not from whatever EX/MEM holds.
  logic [1:0] lat_addr_lo;
  size_e      lat_size;
  logic       lat_sign;
  logic       lat_load;

  // FSM decisions for this cycle
  logic start;
  logic drop_misal;
  logic complete;
  logic abort;

  // Lane steering: issue uses the live EX/MEM fields, completion the latched ones.
  logic [1:0]  al_addr_lo;
  size_e       al_size;
  logic        al_sign;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  assign al_addr_lo = (state_q == BUSY) ? lat_addr_lo : alu_c_in[1:0];
  assign al_size    = (state_q == BUSY) ? lat_size    : dec.size;
  assign al_sign    = (state_q == BUSY) ? lat_sign    : dec.sign;

  mem_lane_align u_align (
    .addr_lo   (al_addr_lo),
    .size      (al_size),
    .sign      (al_sign),
    .rt        (rt_data_in),
    .rdata     (dm_rdata),
    .be        (al_be),
    .wdata     (al_wdata),
    .load_data (al_load)
  );

  // Opcode operand fields are not needed in this stage.
  logic unused_instr;
  assign unused_instr = ^instr_in[25:0];

  // Next state and stall. mem_stall depends on dm_ready but never on dm_rdata.
  always_comb begin
    state_d    = state_q;
    mem_stall  = 1'b0;
    start      = 1'b0;
    drop_misal = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (mis) begin
            drop_misal = 1'b1;
          end else begin
            start     = 1'b1;
            mem_stall = 1'b1;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        // Completion takes priority over a timeout in the same cycle.
        if (dm_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timeout counter and latched access attributes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      lat_addr_lo <= 2'b00;
      lat_size    <= SZ_B;
      lat_sign    <= 1'b0;
      lat_load    <= 1'b0;
    end else if (start) begin
      cnt_q       <= '0;
      lat_addr_lo <= alu_c_in[1:0];
      lat_size    <= dec.size;
      lat_sign    <= dec.sign;
      lat_load    <= ~memw_in;
    end else if ((state_q == BUSY) && !dm_ready && !abort) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Bus request registers; dropped asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= 32'h0;
      dm_be    <= 4'h0;
      dm_wdata <= 32'h0;
    end else if (start) begin
      dm_req   <= 1'b1;
      dm_we    <= memw_in;
      dm_addr  <= {alu_c_in[31:2], 2'b00};
      dm_be    <= al_be;
      dm_wdata <= al_wdata;
    end else if (complete || abort) begin
      dm_req <= 1'b0;
    end
  end

  // Error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      misalign <= drop_misal;
      bus_err  <= abort;
    end
  end

  // MEM/WB register. Accesses retire only on completion; every other
  // memory-related cycle inserts a bubble (no register write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_regw      <= 1'b0;
      wb_mem2r     <= 1'b0;
      wb_rd        <= 5'h0;
      wb_alu_c     <= 32'h0;
      wb_load_data <= 32'h0;
    end else if (state_q == IDLE) begin
      wb_rd        <= reg_rd_in;
      wb_alu_c     <= alu_c_in;
      wb_load_data <= 32'h0;
      if (access) begin
        wb_regw  <= 1'b0;
        wb_mem2r <= 1'b0;
      end else begin
        wb_regw  <= regw_in;
        wb_mem2r <= mem2r_in;
      end
    end else if (complete) begin
      wb_regw      <= regw_in;
      wb_mem2r     <= mem2r_in;
      wb_rd        <= reg_rd_in;
      wb_alu_c     <= alu_c_in;
      wb_load_data <= lat_load ? al_load : 32'h0;
    end else begin
      wb_regw      <= 1'b0;
      wb_mem2r     <= 1'b0;
      wb_load_data <= 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: table of single-access vectors with hand-computed
// results, plus directed sequences for stall length, timeout, IDLE dm_ready
// and reset during an outstanding access.
module tb_mem_access_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        memr_in, memw_in, regw_in, mem2r_in;
  logic [4:0]  reg_rd_in;
  logic [31:0] alu_c_in, rt_data_in, instr_in;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_stall, misalign, bus_err;
  logic        wb_regw, wb_mem2r;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_c, wb_load_data;

  mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .memr_in      (memr_in),
    .memw_in      (memw_in),
    .regw_in      (regw_in),
    .mem2r_in     (mem2r_in),
    .reg_rd_in    (reg_rd_in),
    .alu_c_in     (alu_c_in),
    .rt_data_in   (rt_data_in),
    .instr_in     (instr_in),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_be        (dm_be),
    .dm_wdata     (dm_wdata),
    .dm_ready     (dm_ready),
    .dm_rdata     (dm_rdata),
    .mem_stall    (mem_stall),
    .misalign     (misalign),
    .bus_err      (bus_err),
    .wb_regw      (wb_regw),
    .wb_mem2r     (wb_mem2r),
    .wb_rd        (wb_rd),
    .wb_alu_c     (wb_alu_c),
    .wb_load_data (wb_load_data)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // kind: 0 = non-access, 1 = aligned access (ready on first BUSY cycle), 2 = misaligned
  typedef struct {
    string       name;
    int          kind;
    logic        memr, memw, regw, mem2r;
    logic [4:0]  rd;
    logic [31:0] addr, rt;
    logic [5:0]  op;
    logic [31:0] rdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_daddr;
    logic        exp_wbregw;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input int kind,
      input logic memr, input logic memw, input logic regw, input logic mem2r,
      input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] rt,
      input logic [5:0] op, input logic [31:0] rdata, input logic exp_we,
      input logic [3:0] exp_be, input logic [31:0] exp_wdata,
      input logic [31:0] exp_daddr, input logic exp_wbregw, input logic [31:0] exp_ld);
    vec_t v;
    v.name = name; v.kind = kind; v.memr = memr; v.memw = memw; v.regw = regw;
    v.mem2r = mem2r; v.rd = rd; v.addr = addr; v.rt = rt; v.op = op; v.rdata = rdata;
    v.exp_we = exp_we; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
    v.exp_daddr = exp_daddr; v.exp_wbregw = exp_wbregw; v.exp_ld = exp_ld;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic memr, input logic memw, input logic regw,
      input logic mem2r, input logic [4:0] rd, input logic [31:0] addr,
      input logic [31:0] rt, input logic [5:0] op);
    memr_in    = memr;
    memw_in    = memw;
    regw_in    = regw;
    mem2r_in   = mem2r;
    reg_rd_in  = rd;
    alu_c_in   = addr;
    rt_data_in = rt;
    instr_in   = {op, 26'h0};
  endtask

  task automatic drive_nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 6'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    drive(v.memr, v.memw, v.regw, v.mem2r, v.rd, v.addr, v.rt, v.op);
    @(negedge clk);
    chk({v.name, ".stall_issue"}, {31'h0, mem_stall}, (v.kind == 1) ? 32'h1 : 32'h0);
    tick();
    if (v.kind == 1) begin
      chk({v.name, ".dm_req"},   {31'h0, dm_req}, 32'h1);
      chk({v.name, ".dm_we"},    {31'h0, dm_we},  {31'h0, v.exp_we});
      chk({v.name, ".dm_be"},    {28'h0, dm_be},  {28'h0, v.exp_be});
      chk({v.name, ".dm_wdata"}, dm_wdata, v.exp_wdata);
      chk({v.name, ".dm_addr"},  dm_addr,  v.exp_daddr);
      chk({v.name, ".wb_bubble"}, {31'h0, wb_regw}, 32'h0);
      dm_ready = 1'b1;
      dm_rdata = v.rdata;
      @(negedge clk);
      chk({v.name, ".stall_done"}, {31'h0, mem_stall}, 32'h0);
      tick();
      dm_ready = 1'b0;
      dm_rdata = 32'h0;
      chk({v.name, ".dm_req_drop"}, {31'h0, dm_req}, 32'h0);
      chk({v.name, ".wb_regw"}, {31'h0, wb_regw}, {31'h0, v.exp_wbregw});
      chk({v.name, ".wb_load_data"}, wb_load_data, v.exp_ld);
      chk({v.name, ".wb_rd"}, {27'h0, wb_rd}, {27'h0, v.rd});
      drive_nop();
    end else if (v.kind == 2) begin
      chk({v.name, ".misalign"}, {31'h0, misalign}, 32'h1);
      chk({v.name, ".dm_req"},   {31'h0, dm_req},   32'h0);
      chk({v.name, ".wb_regw"},  {31'h0, wb_regw},  32'h0);
      drive_nop();
      tick();
      chk({v.name, ".misalign_pulse"}, {31'h0, misalign}, 32'h0);
    end else begin
      chk({v.name, ".wb_regw"},  {31'h0, wb_regw}, {31'h0, v.exp_wbregw});
      chk({v.name, ".wb_alu_c"}, wb_alu_c, v.addr);
      chk({v.name, ".wb_rd"},    {27'h0, wb_rd}, {27'h0, v.rd});
      chk({v.name, ".wb_load_data"}, wb_load_data, v.exp_ld);
      drive_nop();
    end
  endtask

  // ---------------- test ----------------
  int stall_cnt;

  initial begin
    drive_nop();
    dm_ready = 1'b0;
    dm_rdata = 32'h0;

    //                 name      kind r  w  rg m2 rd  addr          rt            op     rdata         we be       wdata         daddr         wb ld
    vecs.push_back(mk("alu",     0, 0, 0, 1, 0, 5,  32'h0000_1234, 32'h0,        6'h00, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 32'h0));
    vecs.push_back(mk("lb",      1, 1, 0, 1, 1, 6,  32'h0000_0103, 32'h0,        6'h20, 32'h80FF0000, 0, 4'b1000, 32'h0,        32'h100,      1, 32'hFFFFFF80));
    vecs.push_back(mk("lbu",     1, 1, 0, 1, 1, 6,  32'h0000_0103, 32'h0,        6'h24, 32'h80FF0000, 0, 4'b1000, 32'h0,        32'h100,      1, 32'h00000080));
    vecs.push_back(mk("lh",      1, 1, 0, 1, 1, 7,  32'h0000_0102, 32'h0,        6'h21, 32'h80FF0000, 0, 4'b1100, 32'h0,        32'h100,      1, 32'hFFFF80FF));
    vecs.push_back(mk("lhu",     1, 1, 0, 1, 1, 8,  32'h0000_0100, 32'h0,        6'h25, 32'h80FF1234, 0, 4'b0011, 32'h0,        32'h100,      1, 32'h00001234));
    vecs.push_back(mk("lw",      1, 1, 0, 1, 1, 9,  32'h0000_0104, 32'h0,        6'h23, 32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'h104,      1, 32'hDEADBEEF));
    vecs.push_back(mk("sh",      1, 0, 1, 0, 0, 0,  32'h0000_0102, 32'h1234ABCD, 6'h29, 32'h0,        1, 4'b1100, 32'hABCDABCD, 32'h100,      0, 32'h0));
    vecs.push_back(mk("sb",      1, 0, 1, 0, 0, 0,  32'h0000_0101, 32'h000000A5, 6'h28, 32'h0,        1, 4'b0010, 32'hA5A5A5A5, 32'h100,      0, 32'h0));
    vecs.push_back(mk("sw",      1, 0, 1, 0, 0, 0,  32'h0000_020C, 32'hCAFEF00D, 6'h2B, 32'h0,        1, 4'b1111, 32'hCAFEF00D, 32'h20C,      0, 32'h0));
    vecs.push_back(mk("rw_both", 1, 1, 1, 0, 0, 0,  32'h0000_0010, 32'h11223344, 6'h2B, 32'h0,        1, 4'b1111, 32'h11223344, 32'h10,       0, 32'h0));
    vecs.push_back(mk("lw_mis",  2, 1, 0, 1, 1, 3,  32'h0000_0102, 32'h0,        6'h23, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk("lh_mis",  2, 1, 0, 1, 1, 3,  32'h0000_0101, 32'h0,        6'h21, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk("unsup",   0, 1, 0, 1, 0, 9,  32'h0000_0040, 32'h0,        6'h22, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 32'h0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.dm_req",   {31'h0, dm_req},   32'h0);
    chk("rst.wb_regw",  {31'h0, wb_regw},  32'h0);
    chk("rst.wb_alu_c", wb_alu_c,          32'h0);
    chk("rst.misalign", {31'h0, misalign}, 32'h0);
    chk("rst.bus_err",  {31'h0, bus_err},  32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // LW with dm_ready on the 4th BUSY cycle: 4 stall cycles, one-cycle retire.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h100, 32'h0, 6'h23);
    stall_cnt = 0;
    @(negedge clk);
    if (mem_stall) stall_cnt++;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        dm_ready = 1'b1;
        dm_rdata = 32'hDEADBEEF;
      end
      @(negedge clk);
      if (mem_stall) stall_cnt++;
      tick();
    end
    dm_ready = 1'b0;
    dm_rdata = 32'h0;
    chk("lw_wait.stall_cycles", stall_cnt, 32'd4);
    chk("lw_wait.wb_regw", {31'h0, wb_regw}, 32'h1);
    chk("lw_wait.wb_load_data", wb_load_data, 32'hDEADBEEF);
    drive_nop();
    tick();
    chk("lw_wait.wb_regw_once", {31'h0, wb_regw}, 32'h0);
    chk("lw_wait.wb_ld_clear", wb_load_data, 32'h0);

    // dm_ready while IDLE is ignored.
    dm_ready = 1'b1;
    dm_rdata = 32'h5555AAAA;
    @(negedge clk);
    chk("idle_ready.stall", {31'h0, mem_stall}, 32'h0);
    tick();
    dm_ready = 1'b0;
    chk("idle_ready.dm_req", {31'h0, dm_req}, 32'h0);
    chk("idle_ready.wb_ld", wb_load_data, 32'h0);

    // Timeout: dm_ready held low.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h200, 32'h0, 6'h23);
    stall_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!mem_stall) break;
      stall_cnt++;
      if (k == 1) chk("timeout.dm_req_busy", {31'h0, dm_req}, 32'h1);
      tick();
    end
    chk("timeout.stall_cycles", stall_cnt, 32'd16);
    tick();
    chk("timeout.bus_err", {31'h0, bus_err}, 32'h1);
    chk("timeout.dm_req",  {31'h0, dm_req},  32'h0);
    chk("timeout.wb_regw", {31'h0, wb_regw}, 32'h0);
    drive_nop();
    @(negedge clk);
    chk("timeout.stall_released", {31'h0, mem_stall}, 32'h0);
    tick();
    chk("timeout.bus_err_pulse", {31'h0, bus_err}, 32'h0);

    // Reset asserted while BUSY.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h77, 32'h0, 6'h00);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h300, 32'h0, 6'h23);
    tick();
    chk("rst_busy.dm_req_before", {31'h0, dm_req}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_busy.dm_req", {31'h0, dm_req}, 32'h0);
    chk("rst_busy.wb_regw", {31'h0, wb_regw}, 32'h0);
    chk("rst_busy.wb_alu_c", wb_alu_c, 32'h0);
    drive_nop();
    #1;
    chk("rst_busy.stall", {31'h0, mem_stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    // Back-to-back ALU ops after reset.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h55, 32'h0, 6'h00);
    @(negedge clk);
    chk("post_rst.alu1_stall", {31'h0, mem_stall}, 32'h0);
    tick();
    chk("post_rst.alu1_wb_alu_c", wb_alu_c, 32'h55);
    chk("post_rst.alu1_wb_regw", {31'h0, wb_regw}, 32'h1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 32'h66, 32'h0, 6'h00);
    @(negedge clk);
    chk("post_rst.alu2_stall", {31'h0, mem_stall}, 32'h0);
    tick();
    chk("post_rst.alu2_wb_alu_c", wb_alu_c, 32'h66);
    chk("post_rst.alu2_wb_rd", {27'h0, wb_rd}, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
